ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL provide: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL provide: btnc_i  input  1  reset; synchronous, active-high.
REQ-003 SHALL provide: op_valid  input  1  EX-stage R-type instruction present (from ID/EX register).
REQ-004 SHALL provide: flush  input  1  EX instruction squashed this cycle (branch taken).
REQ-005 SHALL provide: funct  input  6  funct field of the EX instruction.
REQ-006 SHALL provide: rs_val  input  32  operand A (dividend / multiplicand), already forwarded.
REQ-007 SHALL provide: rt_val  input  32  operand B (divisor / multiplier), already forwarded.
REQ-008 SHALL provide: hi, lo  output  32 each  architectural HI/LO registers.
REQ-009 SHALL provide: mf_data  output  32  MFHI/MFLO read data; combinational from hi/lo.
REQ-010 SHALL provide: busy  output  1  iterative operation in progress.
REQ-011 SHALL provide: stall  output  1  freeze PC, IF/ID, ID/EX; combinational.
REQ-012 SHALL provide: done  output  1  one-cycle pulse on HI/LO update by mult/div.

Function
REQ-013 SHALL decode funct: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x10 MFHI, 0x12 MFLO, 0x11 MTHI, 0x13 MTLO; others ignored.
REQ-014 SHALL define hit = op_valid & !flush & funct in the eight codes above.
REQ-015 SHALL use FSM states IDLE, RUN; IDLE->RUN when hit & mult/div & state==IDLE; RUN->IDLE when iteration counter reaches 31.
REQ-016 SHALL latch operands and op type on the IDLE->RUN edge; signed ops convert to magnitudes and record result signs.
REQ-017 SHALL run exactly 32 RUN cycles (5-bit counter, 0..31): multiply = shift-add one bit per cycle into 64-bit product; divide = restoring, one quotient bit per cycle.
REQ-018 SHALL, on the RUN->IDLE edge, write HI/LO and assert done for the next cycle only; busy = (state==RUN).
REQ-019 SHALL write MULT/MULTU: {HI,LO} = 64-bit product; MULT two's-complement-negated when operand signs differ.
REQ-020 SHALL write DIV/DIVU: LO = quotient, HI = remainder; DIV quotient negative iff signs differ, remainder takes dividend sign.
REQ-021 SHALL handle divisor 0: complete after 32 cycles with LO=0xFFFFFFFF, HI=rs_val as latched; no exception.
REQ-022 SHALL give DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-023 SHALL apply MTHI/MTLO in IDLE on the same edge (HI or LO <= rs_val); single cycle, no done.
REQ-024 SHALL drive mf_data = hi for MFHI, lo for MFLO, else 0.
REQ-025 SHALL assert stall = hit & busy; stalled instruction retained upstream, accepted first cycle busy=0.
REQ-026 SHALL accept a new op in the done cycle (state already IDLE); MFHI there returns the new result.
REQ-027 SHALL ignore flush once in RUN: running op completes and commits.
REQ-028 SHALL suppress start and MT writes when flush=1 in the same cycle.

Reset
REQ-029 SHALL, when btnc_i=1 at a rising edge, set state=IDLE, counter=0, hi=lo=0, done=0, busy=0, regardless of current state, including mid-RUN (result discarded).
REQ-030 SHALL give reset priority over start, MT writes and completion in the same cycle.

Verification
REQ-031 SHALL test MULTU rs=7, rt=6 at edge E0 -> busy E0..E32, at E32 lo=42, hi=0, done=1 one cycle.
REQ-032 SHALL test MULT rs=-3, rt=5 -> lo=0xFFFFFFF1, hi=0xFFFFFFFF; DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 SHALL test DIVU rs=0x1234, rt=0 -> after 32 cycles lo=0xFFFFFFFF, hi=0x1234.
REQ-034 SHALL test MFHI issued 1 cycle after MULT -> stall=1 for 31 cycles; MFHI accepted in done cycle with mf_data=new hi.
REQ-035 SHALL test btnc_i=1 at RUN cycle 10 -> next cycle busy=0, hi=lo=0, done never pulses.
REQ-036 SHALL test MULT with flush=1 -> no start, busy=0; MTLO rs=0xA5A5A5A5 flush=0 -> lo=0xA5A5A5A5 next cycle.

Source files
------------

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_if
//  Description : EX-stage bundle between the pipeline and the multiply/divide
//                unit.
//                Pipeline -> unit : op_valid, flush, funct, rs_val, rt_val
//                Unit -> pipeline : hi, lo, mf_data, busy, stall, done
//                The pipeline side uses the master modport and the unit uses
//                the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_muldiv_if;
  logic        op_valid;
  logic        flush;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;
  logic        busy;
  logic        stall;
  logic        done;

  modport master (
    output op_valid, flush, funct, rs_val, rt_val,
    input  hi, lo, mf_data, busy, stall, done
  );

  modport slave (
    input  op_valid, flush, funct, rs_val, rt_val,
    output hi, lo, mf_data, busy, stall, done
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv
//  Description : Iterative HI/LO multiply/divide unit for the EX stage.
//                MULT/MULTU use shift-add and DIV/DIVU use a restoring
//                divider. Each produces one bit per cycle over exactly 32 RUN
//                cycles. MTHI/MTLO write in a single cycle, and MFHI/MFLO read
//                combinationally.
//  Ports       : clk     - pipeline clock, rising edge
//                btnc_i  - synchronous active-high reset
//                bus     - ex_muldiv_if.slave:
//                          op_valid, flush, funct, rs_val, rt_val (in)
//                          hi, lo, mf_data, busy, stall, done     (out)
//  Revision    : 1.0  initial release
// ============================================================================
module ex_muldiv (
  input  logic       clk,
  input  logic       btnc_i,
  ex_muldiv_if.slave bus
);

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  // Operation context captured when an iteration starts.
  logic        is_div;
  logic        neg_res;   // negate product or quotient
  logic        neg_rem;   // remainder takes the dividend sign
  logic        div_zero;
  logic [31:0] opm;       // multiplicand or divisor magnitude
  // Multiply: running 64-bit product, whose low half also holds the
  // multiplier bits still to be consumed.
  // Divide: {partial remainder, dividend bits shifting out / quotient in}.
  logic [63:0] acc;

  // Decode
  logic        known;
  logic        muldiv_op;
  logic        signed_op;
  logic        div_op;
  logic        mthi_op;
  logic        mtlo_op;
  logic        hit;
  logic        start;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  always_comb begin
    known     = 1'b0;
    muldiv_op = 1'b0;
    signed_op = 1'b0;
    div_op    = 1'b0;
    mthi_op   = 1'b0;
    mtlo_op   = 1'b0;
    case (bus.funct)
      FN_MULT:  begin known = 1'b1; muldiv_op = 1'b1; signed_op = 1'b1; end
      FN_MULTU: begin known = 1'b1; muldiv_op = 1'b1; end
      FN_DIV:   begin known = 1'b1; muldiv_op = 1'b1; signed_op = 1'b1; div_op = 1'b1; end
      FN_DIVU:  begin known = 1'b1; muldiv_op = 1'b1; div_op = 1'b1; end
      FN_MFHI:  known = 1'b1;
      FN_MFLO:  known = 1'b1;
      FN_MTHI:  begin known = 1'b1; mthi_op = 1'b1; end
      FN_MTLO:  begin known = 1'b1; mtlo_op = 1'b1; end
      default:  known = 1'b0;
    endcase
  end

  assign hit   = bus.op_valid & ~bus.flush & known;
  assign start = hit & muldiv_op & (state == IDLE);
  assign abs_a = (signed_op && bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
  assign abs_b = (signed_op && bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;

  // One iteration step, plus the sign-corrected result for the final step.
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [33:0] div_trial;
  logic [63:0] acc_next;
  logic [63:0] prod_fin;
  logic [31:0] quot_fin;
  logic [31:0] rem_fin;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opm} : 33'd0);
    div_sh    = {acc[63:32], acc[31]};
    div_trial = {1'b0, div_sh} - {2'b00, opm};
    if (is_div) begin
      // Restoring step: keep the shifted remainder when the trial goes negative.
      if (div_trial[33])
        acc_next = {div_sh[31:0], acc[30:0], 1'b0};
      else
        acc_next = {div_trial[31:0], acc[30:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[31:1]};
    end
    prod_fin = neg_res ? -acc_next : acc_next;
    // A zero divisor gives an all-ones quotient before any sign correction.
    // The remainder is then the dividend magnitude, and restoring its sign
    // gives back the original rs_val.
    quot_fin = div_zero ? 32'hFFFF_FFFF
                        : (neg_res ? -acc_next[31:0] : acc_next[31:0]);
    rem_fin  = neg_rem ? -acc_next[63:32] : acc_next[63:32];
  end

  always_ff @(posedge clk) begin
    if (btnc_i) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opm      <= 32'd0;
      acc      <= 64'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            cnt      <= 5'd0;
            is_div   <= div_op;
            neg_res  <= signed_op & (bus.rs_val[31] ^ bus.rt_val[31]);
            neg_rem  <= signed_op & bus.rs_val[31];
            div_zero <= (bus.rt_val == 32'd0);
            opm      <= div_op ? abs_b : abs_a;
            acc      <= div_op ? {32'd0, abs_a} : {32'd0, abs_b};
          end else if (hit && mthi_op) begin
            hi_q <= bus.rs_val;
          end else if (hit && mtlo_op) begin
            lo_q <= bus.rs_val;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state  <= IDLE;
            done_q <= 1'b1;
            if (is_div) begin
              hi_q <= rem_fin;
              lo_q <= quot_fin;
            end else begin
              hi_q <= prod_fin[63:32];
              lo_q <= prod_fin[31:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state == RUN);
  assign bus.stall   = hit & (state == RUN);
  assign bus.mf_data = (bus.funct == FN_MFHI) ? hi_q :
                       (bus.funct == FN_MFLO) ? lo_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv
//  Description : Self-checking bench for ex_muldiv. It uses a table of
//                mult/div vectors with hand-computed HI/LO results, followed
//                by directed sequences for MT/MF, flush, stall, and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_muldiv;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  logic clk;
  logic btnc_i;
  ex_muldiv_if bus ();

  ex_muldiv dut (
    .clk    (clk),
    .btnc_i (btnc_i),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.funct    = 6'h00;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
  endtask

  // Issue one mult/div and wait for its done pulse, which is expected
  // exactly 32 edges after the start edge.
  task automatic run_op(input vec_t v);
    int got;
    got = 0;
    bus.op_valid = 1'b1;
    bus.funct    = v.funct;
    bus.rs_val   = v.rs;
    bus.rt_val   = v.rt;
    step();                         // start edge E0
    idle_inputs();
    check({v.name, " busy after start"}, 64'(bus.busy), 64'd1);
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.done) begin
        got = i;
        break;
      end
    end
    check({v.name, " latency"}, 64'(got), 64'd32);
    check({v.name, " busy at done"}, 64'(bus.busy), 64'd0);
    check({v.name, " hi"}, 64'(bus.hi), 64'(v.hi));
    check({v.name, " lo"}, 64'(bus.lo), 64'(v.lo));
    step();
    check({v.name, " done one cycle"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int cnt;

    vecs[0]  = '{"multu 7*6",       FN_MULTU, 32'd7,        32'd6,        32'h0000_0000, 32'd42};
    vecs[1]  = '{"mult -3*5",       FN_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{"div -7/2",        FN_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"divu 0x1234/0",   FN_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF};
    vecs[4]  = '{"div min/-1",      FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{"multu max*max",   FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[6]  = '{"mult min*min",    FN_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7]  = '{"divu 100/7",      FN_DIVU,  32'd100,      32'd7,        32'd2,         32'd14};
    vecs[8]  = '{"div 7/-2",        FN_DIV,   32'd7,        32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9]  = '{"div -7/0",        FN_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[10] = '{"mult 12345*-1",   FN_MULT,  32'd12345,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7};

    idle_inputs();
    btnc_i = 1'b1;
    step();
    step();
    btnc_i = 1'b0;
    #1;
    check("reset hi",    64'(bus.hi),    64'd0);
    check("reset lo",    64'(bus.lo),    64'd0);
    check("reset busy",  64'(bus.busy),  64'd0);
    check("reset done",  64'(bus.done),  64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);

    foreach (vecs[i]) run_op(vecs[i]);

    // MTLO / MTHI and the MF read path.
    bus.op_valid = 1'b1; bus.funct = FN_MTLO; bus.rs_val = 32'hA5A5_A5A5;
    step();
    check("mtlo lo", 64'(bus.lo), 64'hA5A5_A5A5);
    check("mtlo no done", 64'(bus.done), 64'd0);
    bus.funct = FN_MTHI; bus.rs_val = 32'h0000_0055;
    step();
    check("mthi hi", 64'(bus.hi), 64'h55);
    bus.funct = FN_MFHI; #1;
    check("mfhi data", 64'(bus.mf_data), 64'h55);
    bus.funct = FN_MFLO; #1;
    check("mflo data", 64'(bus.mf_data), 64'hA5A5_A5A5);
    bus.funct = 6'h20; #1;
    check("mf other data", 64'(bus.mf_data), 64'd0);

    // A flushed MTHI and a flushed MULT must both be suppressed.
    bus.flush = 1'b1; bus.funct = FN_MTHI; bus.rs_val = 32'h1111_1111;
    step();
    check("flushed mthi", 64'(bus.hi), 64'h55);
    bus.funct = FN_MULT; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
    step();
    check("flushed mult busy", 64'(bus.busy), 64'd0);
    idle_inputs();

    // MFHI arrives one cycle after MULTU and stalls until the done cycle.
    bus.op_valid = 1'b1; bus.funct = FN_MULTU;
    bus.rs_val = 32'h0001_0000; bus.rt_val = 32'h0003_0000;
    step();                          // E0
    idle_inputs();
    step();                          // E1
    bus.op_valid = 1'b1; bus.funct = FN_MFHI;
    #1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.stall) break;
      cnt++;
      step();
    end
    check("mfhi stall cycles", 64'(cnt), 64'd31);
    check("mfhi in done cycle", 64'(bus.done), 64'd1);
    check("mfhi new hi", 64'(bus.mf_data), 64'h3);
    // A new op is accepted in the done cycle.
    bus.funct = FN_MTLO; bus.rs_val = 32'h0BAD_F00D;
    step();
    check("mtlo in done cycle", 64'(bus.lo), 64'h0BAD_F00D);
    idle_inputs();

    // A flush while running does not stop the op.
    bus.op_valid = 1'b1; bus.funct = FN_MULTU; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
    step();
    idle_inputs();
    bus.flush = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.done) begin cnt = i; break; end
    end
    check("flush in run latency", 64'(cnt), 64'd32);
    check("flush in run lo", 64'(bus.lo), 64'd81);
    idle_inputs();
    step();

    // Reset at RUN cycle 10 discards the result.
    bus.op_valid = 1'b1; bus.funct = FN_MULTU; bus.rs_val = 32'd5; bus.rt_val = 32'd5;
    step();
    idle_inputs();
    repeat (9) step();
    btnc_i = 1'b1;
    step();
    btnc_i = 1'b0;
    #1;
    check("midrun reset busy", 64'(bus.busy), 64'd0);
    check("midrun reset hi", 64'(bus.hi), 64'd0);
    check("midrun reset lo", 64'(bus.lo), 64'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) cnt++;
    end
    check("midrun reset no done", 64'(cnt), 64'd0);

    // Reset takes priority over a start in the same cycle.
    bus.op_valid = 1'b1; bus.funct = FN_MULT; bus.rs_val = 32'd2; bus.rt_val = 32'd2;
    btnc_i = 1'b1;
    step();
    btnc_i = 1'b0;
    idle_inputs();
    #1;
    check("reset beats start", 64'(bus.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
